// File: rtl/imem_byte_loader.sv
// Byte-serial program loader: synchronizes a pin strobe, assembles framed words and writes the CPU imem.
// Optional build macro IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte to every load frame.
module imem_byte_loader #(
    parameter int         ADDR_W    = 6,
    parameter logic [7:0] CMD_LOAD  = 8'hA5,
    parameter logic [7:0] CMD_START = 8'h5A
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        byte_in,
    input  logic              byte_stb,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        D0,
        D1,
        D2,
        D3,
        CSUM,
        WRITE
    } state_t;

    state_t              state_q, state_d;
    logic                stbMeta_q, stbSync_q, stbLast_q;
    logic [7:0]          byteMeta_q, byteSync_q;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         data_q, data_d;
    logic [ADDR_W-1:0]   wAddr_q, wAddr_d;
    logic [31:0]         wData_q, wData_d;
    logic                we_q, we_d;
    logic                hold_q, hold_d;
    logic                err_q, err_d;
    logic                accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]          csum_q, csum_d;
`endif

    // The byte travels through the same two stages as the strobe, so at the accept
    // cycle byteSync_q holds the value that was stable when the strobe rose.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stbMeta_q  <= 1'b0;
            stbSync_q  <= 1'b0;
            stbLast_q  <= 1'b0;
            byteMeta_q <= 8'h00;
            byteSync_q <= 8'h00;
        end else begin
            stbMeta_q  <= byte_stb;
            stbSync_q  <= stbMeta_q;
            stbLast_q  <= stbSync_q;
            byteMeta_q <= byte_in;
            byteSync_q <= byteMeta_q;
        end
    end

    assign accept = stbSync_q & ~stbLast_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= 32'h0;
            wAddr_q <= '0;
            wData_q <= 32'h0;
            we_q    <= 1'b0;
            hold_q  <= 1'b1;
            err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wAddr_q <= wAddr_d;
            wData_q <= wData_d;
            we_q    <= we_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    // Write-port registers load only when a frame completes, so imem_addr/imem_wdata
    // stay put while the next frame is being assembled.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wAddr_d = wAddr_q;
        wData_d = wData_q;
        we_d    = 1'b0;
        hold_d  = hold_q;
        err_d   = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (byteSync_q == CMD_LOAD) begin
                        state_d = ADDR;
                        hold_d  = 1'b1;
                    end else if (byteSync_q == CMD_START) begin
                        hold_d  = 1'b0;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end
            ADDR: begin
                if (accept) begin
                    addr_d  = byteSync_q[ADDR_W-1:0];
                    state_d = D0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d  = byteSync_q;
`endif
                end
            end
            D0: begin
                if (accept) begin
                    data_d[7:0] = byteSync_q;
                    state_d     = D1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d      = csum_q ^ byteSync_q;
`endif
                end
            end
            D1: begin
                if (accept) begin
                    data_d[15:8] = byteSync_q;
                    state_d      = D2;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d       = csum_q ^ byteSync_q;
`endif
                end
            end
            D2: begin
                if (accept) begin
                    data_d[23:16] = byteSync_q;
                    state_d       = D3;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d        = csum_q ^ byteSync_q;
`endif
                end
            end
            D3: begin
                if (accept) begin
                    data_d[31:24] = byteSync_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d        = csum_q ^ byteSync_q;
                    state_d       = CSUM;
`else
                    wAddr_d       = addr_q;
                    wData_d       = data_d;
                    we_d          = 1'b1;
                    state_d       = WRITE;
`endif
                end
            end
            CSUM: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (accept) begin
                    if (byteSync_q == csum_q) begin
                        wAddr_d = addr_q;
                        wData_d = data_q;
                        we_d    = 1'b1;
                        state_d = WRITE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
`else
                state_d = IDLE;
`endif
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign imem_we    = we_q;
    assign imem_addr  = wAddr_q;
    assign imem_wdata = wData_q;
    assign cpu_hold   = hold_q;
    assign busy       = (state_q != IDLE);
    assign err        = err_q;

endmodule

// File: tb/tb_imem_byte_loader.sv
// Scoreboard bench for imem_byte_loader: stimulus pushes expected imem writes, a monitor pops and compares.
module tb_imem_byte_loader;

    localparam int ADDR_W = 6;

    logic              clk;
    logic              rst;
    logic [7:0]        byte_in;
    logic              byte_stb;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              err;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } expWrite_t;

    expWrite_t sbQ[$];
    int        errors = 0;
    int        checks = 0;
    int        writesSeen = 0;
    int        writesExpected = 0;

    imem_byte_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_in    (byte_in),
        .byte_stb   (byte_stb),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Strobe held high several cycles to confirm a held strobe yields a single byte.
    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk);
        byte_in  = b;
        byte_stb = 1'b1;
        repeat (5) @(negedge clk);
        byte_stb = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Sends a command byte and checks cpu_hold in the accept cycle and the cycle after.
    task automatic applyTimed(input logic [7:0] b, input logic holdInE, input logic holdAfter);
        @(negedge clk);
        byte_in  = b;
        byte_stb = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("holdAtAccept", {31'h0, cpu_hold}, {31'h0, holdInE});
        @(negedge clk);
        checkOutput("holdAfterAccept", {31'h0, cpu_hold}, {31'h0, holdAfter});
        repeat (2) @(negedge clk);
        byte_stb = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic sendBody(input logic [7:0] addrByte, input logic [31:0] data);
        expWrite_t e;
        logic [7:0] cs;
        cs = addrByte ^ data[7:0] ^ data[15:8] ^ data[23:16] ^ data[31:24];
        e.addr = addrByte[ADDR_W-1:0];
        e.data = data;
        applyStimulus(addrByte);
        checkOutput("busyInFrame", {31'h0, busy}, 32'h1);
        applyStimulus(data[7:0]);
        applyStimulus(data[15:8]);
        applyStimulus(data[23:16]);
        sbQ.push_back(e);
        writesExpected++;
`ifdef IMEM_LOADER_CHECKSUM_EN
        applyStimulus(data[31:24]);
        applyStimulus(cs);
`else
        applyStimulus(data[31:24]);
`endif
        checkOutput("busyAfterFrame", {31'h0, busy}, 32'h0);
    endtask

    task automatic sendFrame(input logic [7:0] addrByte, input logic [31:0] data);
        applyStimulus(8'hA5);
        sendBody(addrByte, data);
    endtask

    initial begin : monitor
        expWrite_t e;
        forever begin
            @(negedge clk);
            if (!rst && imem_we) begin
                writesSeen++;
                if (sbQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedWrite: got addr %h data %h expected no write", imem_addr, imem_wdata);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("wrAddr", {26'h0, imem_addr}, {26'h0, e.addr});
                    checkOutput("wrData", imem_wdata, e.data);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        int waitCycles;
        rst      = 1'b1;
        byte_in  = 8'h00;
        byte_stb = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("rstHold", {31'h0, cpu_hold}, 32'h1);
        checkOutput("rstBusy", {31'h0, busy}, 32'h0);
        checkOutput("rstErr", {31'h0, err}, 32'h0);
        checkOutput("rstWe", {31'h0, imem_we}, 32'h0);
        checkOutput("rstAddr", {26'h0, imem_addr}, 32'h0);
        checkOutput("rstWdata", imem_wdata, 32'h0);

        sendFrame(8'h03, 32'h12345678);
        checkOutput("heldAddr", {26'h0, imem_addr}, 32'h3);
        checkOutput("heldData", imem_wdata, 32'h12345678);
        checkOutput("errAfterFrame", {31'h0, err}, 32'h0);

        applyTimed(8'h5A, 1'b1, 1'b0);
        checkOutput("busyAfterStart", {31'h0, busy}, 32'h0);
        applyTimed(8'hA5, 1'b0, 1'b1);
        sendBody(8'h0A, 32'hDEADBEEF);

        applyStimulus(8'h00);
        checkOutput("errUnknownCmd", {31'h0, err}, 32'h1);
        sendFrame(8'h05, 32'hCAFEF00D);
        checkOutput("errSticky", {31'h0, err}, 32'h1);

        applyStimulus(8'hA5);
        applyStimulus(8'h07);
        applyStimulus(8'hAA);
        #2 rst = 1'b1;
        #1;
        checkOutput("midRstBusy", {31'h0, busy}, 32'h0);
        checkOutput("midRstHold", {31'h0, cpu_hold}, 32'h1);
        checkOutput("midRstErr", {31'h0, err}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        sendFrame(8'h07, 32'h0BADF00D);

        sendFrame(8'hC5, 32'h11223344);
        checkOutput("truncAddr", {26'h0, imem_addr}, 32'h5);
        sendFrame(8'h03, 32'hA5A5A5A5);

`ifdef IMEM_LOADER_CHECKSUM_EN
        applyStimulus(8'hA5);
        applyStimulus(8'h03);
        applyStimulus(8'h78);
        applyStimulus(8'h56);
        applyStimulus(8'h34);
        applyStimulus(8'h12);
        applyStimulus(8'h00);
        checkOutput("csumBadErr", {31'h0, err}, 32'h1);
        checkOutput("csumBadBusy", {31'h0, busy}, 32'h0);
        checkOutput("csumBadAddrKept", {26'h0, imem_addr}, 32'h3);
        checkOutput("csumBadDataKept", imem_wdata, 32'hA5A5A5A5);
`endif

        waitCycles = 0;
        while (sbQ.size() != 0 && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("pendingWrites", sbQ.size(), 32'h0);
        checkOutput("writeCount", writesSeen, writesExpected);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
